// File: rtl/arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic units.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for serial_subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );

endinterface

// File: rtl/full_subtractor.sv
// Combinational one-bit full-subtractor cell, borrow in place of carry.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell and a registered borrow.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bo;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .diff (d),
        .bout (bo)
    );

    // Result bits enter a_sr at the top as minuend bits leave the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr     <= bus.a;
                        b_sr     <= bus.b;
                        borrow   <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= {d, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    borrow <= bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.diff <= {d, a_sr[WIDTH-1:1]};
                        bus.bout <= bo;
                        bus.ovf  <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 directed ops, WIDTH=4 exhaustive, cell truth table.
module tb_serial_subtractor;

    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(8)) s8 ();
    serial_subtractor_if #(.WIDTH(4)) s4 ();

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (s8.slave)
    );

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (s4.slave)
    );

    logic fx, fy, fb, fd, fo;

    full_subtractor u_fs (
        .a    (fx),
        .b    (fy),
        .bin  (fb),
        .diff (fd),
        .bout (fo)
    );

    int checks   = 0;
    int failures = 0;
    int tcyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        tcyc++;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference result packed as {ovf, bout, diff[7:0]}, from plain arithmetic.
    function automatic logic [9:0] ref_sub(input int w, input logic [7:0] a,
                                           input logic [7:0] b);
        int ua, ub, sa, sb, sd, mask;
        logic [9:0] r;
        mask = (1 << w) - 1;
        ua = int'(a) & mask;
        ub = int'(b) & mask;
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        sd = sa - sb;
        r[7:0] = 8'((ua - ub) & mask);
        r[8]   = (ua < ub);
        r[9]   = (sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1)));
        return r;
    endfunction

    // Transaction-level model: an accepted op finishes WIDTH edges later.
    int         mcyc[2];
    int         mdue[2];
    int         mdcyc[2];
    bit         mact[2];
    logic [9:0] mres[2];
    logic [9:0] mpend[2];

    task automatic mreset(input int k);
        mcyc[k]  = 0;
        mdue[k]  = 0;
        mdcyc[k] = -1;
        mact[k]  = 1'b0;
        mres[k]  = '0;
        mpend[k] = '0;
    endtask

    task automatic mstep(input int k, input int w, input logic st,
                         input logic [7:0] ia, input logic [7:0] ib);
        mcyc[k]++;
        if (mact[k]) begin
            if (mcyc[k] == mdue[k]) begin
                mact[k]  = 1'b0;
                mres[k]  = mpend[k];
                mdcyc[k] = mcyc[k];
            end
        end else if (st) begin
            mact[k]  = 1'b1;
            mdue[k]  = mcyc[k] + w;
            mpend[k] = ref_sub(w, ia, ib);
        end
    endtask

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, 8, s8.start, s8.a, s8.b);
            mstep(1, 4, s4.start, {4'h0, s4.a}, {4'h0, s4.b});
        end
    end

    always begin
        @(negedge clk);
        if (!rst) begin
            chk("m8_busy", s8.busy, mact[0]);
            chk("m8_done", s8.done, mdcyc[0] == mcyc[0]);
            chk("m8_diff", s8.diff, mres[0][7:0]);
            chk("m8_bout", s8.bout, mres[0][8]);
            chk("m8_ovf",  s8.ovf,  mres[0][9]);
            chk("m4_busy", s4.busy, mact[1]);
            chk("m4_done", s4.done, mdcyc[1] == mcyc[1]);
            chk("m4_diff", s4.diff, mres[1][3:0]);
            chk("m4_bout", s4.bout, mres[1][8]);
            chk("m4_ovf",  s4.ovf,  mres[1][9]);
        end
    end

    task automatic wait_done(input int k, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((k == 0) ? s8.done : s4.done) begin
                at = tcyc;
                return;
            end
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] ed, input logic eb, input logic eo);
        int e, at;
        s8.a = ia;
        s8.b = ib;
        s8.start = 1'b1;
        e = tcyc + 1;
        @(posedge clk);
        #1;
        s8.start = 1'b0;
        chk("busy_after_start", s8.busy, 1);
        wait_done(0, at);
        chk("latency8", at - e, 8);
        chk("diff8", s8.diff, ed);
        chk("bout8", s8.bout, eb);
        chk("ovf8",  s8.ovf,  eo);
        chk("busy_in_done", s8.busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (s8.done) cnt++;
        end
    endtask

    initial begin
        int at1, at2, e, cnt, prev;
        logic [7:0] pa, pb, ab;

        rst = 1'b1;
        s8.start = 1'b0; s8.a = '0; s8.b = '0;
        s4.start = 1'b0; s4.a = '0; s4.b = '0;
        fx = 1'b0; fy = 1'b0; fb = 1'b0;

        chk("pin_ref_05_03", ref_sub(8, 8'h05, 8'h03), 10'h002);
        chk("pin_ref_03_05", ref_sub(8, 8'h03, 8'h05), 10'h1FE);
        chk("pin_ref_80_01", ref_sub(8, 8'h80, 8'h01), 10'h27F);
        chk("pin_ref_7F_FF", ref_sub(8, 8'h7F, 8'hFF), 10'h380);
        chk("pin_ref4_8_1",  ref_sub(4, 8'h08, 8'h01), 10'h207);

        for (int v = 0; v < 8; v++) begin
            int r;
            fx = v[2]; fy = v[1]; fb = v[0];
            #1;
            r = int'(fx) - int'(fy) - int'(fb);
            chk("cell_diff", fd, r & 1);
            chk("cell_bout", fo, r < 0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", s8.busy, 0);
        chk("rst_done", s8.done, 0);
        chk("rst_diff", s8.diff, 0);
        chk("rst_bout", s8.bout, 0);
        chk("rst_ovf",  s8.ovf,  0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // start held high; operands changed mid-flight
        s8.a = 8'h10; s8.b = 8'h01; s8.start = 1'b1;
        @(posedge clk);
        #1;
        s8.a = 8'h33; s8.b = 8'h11;
        wait_done(0, at1);
        chk("held_first", s8.diff, 8'h0F);
        wait_done(0, at2);
        chk("held_second", s8.diff, 8'h22);
        chk("held_period", at2 - at1, 9);
        s8.start = 1'b0;
        @(posedge clk);
        #1;

        // asynchronous reset in the 4th RUN cycle
        s8.a = 8'h05; s8.b = 8'h03; s8.start = 1'b1;
        @(posedge clk);
        #1;
        s8.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", s8.busy, 0);
        chk("arst_done", s8.done, 0);
        chk("arst_diff", s8.diff, 0);
        chk("arst_bout", s8.bout, 0);
        chk("arst_ovf",  s8.ovf,  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_done(12, cnt);
        chk("arst_no_done", cnt, 0);
        @(posedge clk);
        #1;
        op8(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1);

        // start during RUN is ignored
        s8.a = 8'h05; s8.b = 8'h03; s8.start = 1'b1;
        e = tcyc + 1;
        @(posedge clk);
        #1;
        s8.start = 1'b0;
        @(posedge clk);
        #1;
        s8.a = 8'hFF; s8.b = 8'h00; s8.start = 1'b1;
        @(posedge clk);
        #1;
        s8.start = 1'b0;
        wait_done(0, at1);
        chk("ign_latency", at1 - e, 8);
        chk("ign_diff", s8.diff, 8'h02);
        count_done(12, cnt);
        chk("ign_one_done", cnt, 0);
        @(posedge clk);
        #1;

        // WIDTH=4 exhaustive, back-to-back
        prev = -1;
        for (int i = 0; i < 256; i++) begin
            ab = 8'(i);
            pa = {4'h0, ab[7:4]};
            pb = {4'h0, ab[3:0]};
            s4.a = pa[3:0];
            s4.b = pb[3:0];
            s4.start = 1'b1;
            wait_done(1, at1);
            if (i > 0) chk("period4", at1 - prev, 5);
            prev = at1;
        end
        s4.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
